// File: rtl/picorv32_wb_bridge.sv
// PicoRV32 native memory port to classic single-cycle Wishbone initiator.
// A watchdog ends unacknowledged cycles and returns a fixed error word.

package wb_pkg;

  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
  } wb_h2d_t;

  typedef struct packed {
    logic        ack;
    logic        err;
    logic        rty;
    logic [31:0] dat;
  } wb_d2h_t;

endpackage

module picorv32_wb_bridge
  import wb_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [3:0]  mem_wstrb_i,
  output logic        mem_ready_o,
  output logic [31:0] mem_rdata_o,
  output wb_h2d_t     wb_o,
  input  wb_d2h_t     wb_i,
  output logic        err_o,
  output logic [31:0] err_addr_o,
  input  logic        err_clr_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  // Counter value seen on the edge that closes the last permitted stb cycle.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_reg, state_next;
  wb_h2d_t     wb_reg, wb_next;
  logic [15:0] cnt_reg, cnt_next;
  logic [31:0] rdata_reg, rdata_next;
  logic        ready_reg, ready_next;
  logic        err_reg, err_next;
  logic [31:0] err_addr_reg, err_addr_next;
  logic        err_set;

  // err/rty terminations are not supported; these response bits are ignored.
  logic unused_resp;
  assign unused_resp = &{1'b0, wb_i.err, wb_i.rty};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg    <= IDLE;
      wb_reg       <= '0;
      cnt_reg      <= '0;
      rdata_reg    <= '0;
      ready_reg    <= 1'b0;
      err_reg      <= 1'b0;
      err_addr_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wb_reg       <= wb_next;
      cnt_reg      <= cnt_next;
      rdata_reg    <= rdata_next;
      ready_reg    <= ready_next;
      err_reg      <= err_next;
      err_addr_reg <= err_addr_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    wb_next       = wb_reg;
    cnt_next      = cnt_reg;
    rdata_next    = rdata_reg;
    ready_next    = 1'b0;
    err_addr_next = err_addr_reg;
    err_set       = 1'b0;

    unique case (state_reg)
      IDLE: begin
        wb_next = '0;
        if (mem_valid_i) begin
          wb_next.cyc = 1'b1;
          wb_next.stb = 1'b1;
          wb_next.we  = |mem_wstrb_i;
          wb_next.sel = (|mem_wstrb_i) ? mem_wstrb_i : 4'hF;
          wb_next.adr = mem_addr_i;
          wb_next.dat = mem_wdata_i;
          cnt_next    = '0;
          state_next  = BUS;
        end
      end
      BUS: begin
        // A late ack in the final watchdog cycle still completes normally.
        if (wb_i.ack) begin
          rdata_next = wb_reg.we ? 32'h0 : wb_i.dat;
          wb_next    = '0;
          ready_next = 1'b1;
          state_next = RESP;
        end else if (cnt_reg == CNT_LAST) begin
          rdata_next    = ERR_RDATA;
          err_set       = 1'b1;
          err_addr_next = wb_reg.adr;
          wb_next       = '0;
          ready_next    = 1'b1;
          state_next    = RESP;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      RESP: begin
        wb_next    = '0;
        state_next = IDLE;
      end
      default: begin
        wb_next    = '0;
        state_next = IDLE;
      end
    endcase

    err_next = err_set ? 1'b1 : (err_clr_i ? 1'b0 : err_reg);
  end

  assign mem_ready_o = ready_reg;
  assign mem_rdata_o = rdata_reg;
  assign wb_o        = wb_reg;
  assign err_o       = err_reg;
  assign err_addr_o  = err_addr_reg;

endmodule

// File: tb/tb_picorv32_wb_bridge.sv
// Directed bench for picorv32_wb_bridge with a 16-cycle watchdog.
// The bench plays both CPU and Wishbone slave from one linear sequence.

module tb_picorv32_wb_bridge;
  import wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  wb_h2d_t     wb_req;
  wb_d2h_t     wb_rsp;
  logic        err;
  logic [31:0] err_addr;
  logic        err_clr;

  int checks = 0;
  int passes = 0;
  int n;

  always #5 clk = ~clk;

  picorv32_wb_bridge #(
    .TIMEOUT_CYCLES(16),
    .ERR_RDATA     (32'hDEAD_BEEF)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .mem_valid_i(mem_valid),
    .mem_addr_i (mem_addr),
    .mem_wdata_i(mem_wdata),
    .mem_wstrb_i(mem_wstrb),
    .mem_ready_o(mem_ready),
    .mem_rdata_o(mem_rdata),
    .wb_o       (wb_req),
    .wb_i       (wb_rsp),
    .err_o      (err),
    .err_addr_o (err_addr),
    .err_clr_i  (err_clr)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " wb_o"}, 128'(wb_req), 128'h0);
    check({tag, " ready"}, 128'(mem_ready), 128'h0);
    check({tag, " rdata"}, 128'(mem_rdata), 128'h0);
    check({tag, " err"}, 128'(err), 128'h0);
    check({tag, " err_addr"}, 128'(err_addr), 128'h0);
  endtask

  initial begin
    rst       = 1'b1;
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    wb_rsp    = '0;
    err_clr   = 1'b0;

    // Reset state
    tick();
    tick();
    check_idle_outputs("reset");
    rst = 1'b0;
    tick();
    check("post-reset stb", 128'(wb_req.stb), 128'h0);

    // Zero-wait read
    mem_valid = 1'b1;
    mem_addr  = 32'h1000_0004;
    mem_wstrb = 4'h0;
    tick();                                  // E0
    mem_valid = 1'b0;
    check("rd0 stb", 128'(wb_req.stb), 128'h1);
    check("rd0 cyc", 128'(wb_req.cyc), 128'h1);
    check("rd0 we", 128'(wb_req.we), 128'h0);
    check("rd0 sel", 128'(wb_req.sel), 128'hF);
    check("rd0 adr", 128'(wb_req.adr), 128'h1000_0004);
    check("rd0 ready early", 128'(mem_ready), 128'h0);
    wb_rsp.ack = 1'b1;
    wb_rsp.dat = 32'h1234_5678;
    tick();                                  // E1
    wb_rsp = '0;
    check("rd0 ready", 128'(mem_ready), 128'h1);
    check("rd0 rdata", 128'(mem_rdata), 128'h1234_5678);
    check("rd0 wb dropped", 128'(wb_req), 128'h0);
    tick();                                  // E2
    check("rd0 ready pulse end", 128'(mem_ready), 128'h0);
    check("rd0 rdata hold", 128'(mem_rdata), 128'h1234_5678);
    $display("txn read  addr=%08h rdata=%08h", 32'h1000_0004, mem_rdata);

    // Byte write with three wait states
    mem_valid = 1'b1;
    mem_addr  = 32'h2000_0008;
    mem_wdata = 32'h0000_A500;
    mem_wstrb = 4'b0010;
    tick();                                  // E0
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    mem_wdata = 32'hFFFF_FFFF;
    mem_addr  = 32'hFFFF_FFFF;
    check("wr we", 128'(wb_req.we), 128'h1);
    check("wr sel", 128'(wb_req.sel), 128'h2);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("wr stb c%0d", i), 128'(wb_req.stb), 128'h1);
      check($sformatf("wr adr c%0d", i), 128'(wb_req.adr), 128'h2000_0008);
      check($sformatf("wr dat c%0d", i), 128'(wb_req.dat), 128'h0000_A500);
      check($sformatf("wr ready c%0d", i), 128'(mem_ready), 128'h0);
      if (i == 4) wb_rsp.ack = 1'b1;
      tick();
    end
    wb_rsp = '0;
    check("wr ready", 128'(mem_ready), 128'h1);
    check("wr rdata", 128'(mem_rdata), 128'h0);
    check("wr stb dropped", 128'(wb_req.stb), 128'h0);
    tick();
    check("wr ready pulse end", 128'(mem_ready), 128'h0);
    $display("txn write addr=%08h wdata=%08h wstrb=0010", 32'h2000_0008, 32'h0000_A500);

    // Unmapped read times out
    mem_valid = 1'b1;
    mem_addr  = 32'hF000_0000;
    tick();                                  // E0
    mem_valid = 1'b0;
    n = 0;
    while (wb_req.stb && n < 40) begin
      check($sformatf("to ready c%0d", n + 1), 128'(mem_ready), 128'h0);
      n++;
      tick();
    end
    check("to stb cycles", 128'(n), 128'd16);
    check("to ready", 128'(mem_ready), 128'h1);
    check("to rdata", 128'(mem_rdata), 128'hDEAD_BEEF);
    check("to err", 128'(err), 128'h1);
    check("to err_addr", 128'(err_addr), 128'hF000_0000);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("to err cleared", 128'(err), 128'h0);
    check("to err_addr kept", 128'(err_addr), 128'hF000_0000);
    $display("txn read  addr=%08h timeout rdata=%08h", 32'hF000_0000, mem_rdata);

    // Ack lands in the final watchdog cycle
    mem_valid = 1'b1;
    mem_addr  = 32'h3000_0010;
    tick();
    mem_valid = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      check($sformatf("late stb c%0d", i), 128'(wb_req.stb), 128'h1);
      if (i == 16) begin
        wb_rsp.ack = 1'b1;
        wb_rsp.dat = 32'hCAFE_F00D;
      end
      tick();
    end
    wb_rsp = '0;
    check("late ready", 128'(mem_ready), 128'h1);
    check("late rdata", 128'(mem_rdata), 128'hCAFE_F00D);
    check("late err", 128'(err), 128'h0);
    check("late err_addr", 128'(err_addr), 128'hF000_0000);
    tick();
    $display("txn read  addr=%08h rdata=%08h (ack in last cycle)", 32'h3000_0010, mem_rdata);

    // Timeout coincident with err_clr: set wins
    mem_valid = 1'b1;
    mem_addr  = 32'h4000_0000;
    mem_wdata = 32'h1111_2222;
    mem_wstrb = 4'hF;
    tick();
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    for (int i = 1; i <= 16; i++) begin
      if (i == 16) err_clr = 1'b1;
      tick();
    end
    err_clr = 1'b0;
    check("clr+to ready", 128'(mem_ready), 128'h1);
    check("clr+to err", 128'(err), 128'h1);
    check("clr+to err_addr", 128'(err_addr), 128'h4000_0000);
    check("clr+to rdata", 128'(mem_rdata), 128'hDEAD_BEEF);
    tick();
    check("clr+to err sticky", 128'(err), 128'h1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("clr alone err", 128'(err), 128'h0);
    check("clr alone err_addr", 128'(err_addr), 128'h4000_0000);
    $display("txn write addr=%08h timeout with err_clr", 32'h4000_0000);

    // Reset during a wait state, then a stray ack
    mem_valid = 1'b1;
    mem_addr  = 32'h5000_0000;
    mem_wdata = 32'h0000_00FF;
    mem_wstrb = 4'b0001;
    tick();
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    check("rst mid stb", 128'(wb_req.stb), 128'h1);
    tick();
    #3;
    rst = 1'b1;
    #1;
    check_idle_outputs("rst mid async");
    tick();
    rst = 1'b0;
    wb_rsp.ack = 1'b1;
    wb_rsp.dat = 32'h7777_7777;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check($sformatf("stray ack ready c%0d", i), 128'(mem_ready), 128'h0);
      check($sformatf("stray ack wb c%0d", i), 128'(wb_req), 128'h0);
    end
    wb_rsp = '0;
    check_idle_outputs("after rst");
    $display("txn write addr=%08h aborted by reset", 32'h5000_0000);

    // Bridge still works after the abort
    mem_valid = 1'b1;
    mem_addr  = 32'h1000_0000;
    tick();
    mem_valid = 1'b0;
    wb_rsp.ack = 1'b1;
    wb_rsp.dat = 32'h0BAD_F00D;
    tick();
    wb_rsp = '0;
    check("recover ready", 128'(mem_ready), 128'h1);
    check("recover rdata", 128'(mem_rdata), 128'h0BAD_F00D);
    tick();
    $display("txn read  addr=%08h rdata=%08h", 32'h1000_0000, mem_rdata);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/picorv32_wb_bridge.md
# picorv32_wb_bridge

Wishbone initiator that converts the PicoRV32 native memory interface into single classic-cycle Wishbone transfers. It drives the `wb_h2d_t` request port that feeds the peripheral crossbar and consumes the returned `wb_d2h_t` response. A bus-watchdog terminates any cycle that is never acknowledged, for example an access to an unmapped address. On such a termination it returns a fixed error word and records the faulting address.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: number of cycles `stb` may stay high without `ack` before forced termination. Legal range is 2..65535.
- `ERR_RDATA`, default 32'hDEAD_BEEF: read data returned to the CPU on timeout.

Ports:
- `clk_i`  in  1: single clock. All logic is on the rising edge.
- `rst_i`  in  1: asynchronous, active-high reset.
- `mem_valid_i`  in  1: CPU request valid.
- `mem_addr_i`  in  32: CPU byte address.
- `mem_wdata_i`  in  32: CPU write data.
- `mem_wstrb_i`  in  4: CPU byte strobes. 0 means read.
- `mem_ready_o`  out  1: one-cycle completion pulse.
- `mem_rdata_o`  out  32: read data, valid while `mem_ready_o` = 1.
- `wb_o`  out  `wb_h2d_t`: Wishbone request.
- `wb_i`  in  `wb_d2h_t`: Wishbone response. Only `ack` and read data are used.
- `err_o`  out  1: sticky timeout flag.
- `err_addr_o`  out  32: address of the most recent timed-out access.
- `err_clr_i`  in  1: synchronous clear of `err_o`.

## Operation
- FSM states are IDLE, BUS and RESP. Reset state is IDLE.
- **IDLE**
  - When `mem_valid_i` = 1, register the address, write data and strobes.
  - Next cycle, drive `cyc` = `stb` = 1, `adr` = `mem_addr_i`, `we` = |`mem_wstrb_i`.
  - For writes, `sel` = `mem_wstrb_i`. For reads, `sel` = 4'hF.
  - Clear the watchdog counter and go to BUS.
- **BUS**
  - All request fields are held stable.
  - On sampled `ack` = 1: for a read, capture `wb_i` read data into `mem_rdata_o`; for a write, set `mem_rdata_o` = 0. Drop `cyc`/`stb`/`we`/`sel` to 0 and go to RESP.
  - Otherwise, increment the counter. When the counter reaches `TIMEOUT_CYCLES`-1 with no `ack`:
    - drop the request;
    - set `mem_rdata_o` = `ERR_RDATA` for both reads and writes;
    - set `err_o`, and load `err_addr_o` with the registered address;
    - go to RESP.
  - If `ack` arrives in the timeout cycle, `ack` wins: normal completion, no error.
- **RESP**
  - `mem_ready_o` = 1 for exactly one cycle, then go to IDLE.
  - `mem_rdata_o` holds its value until the next completion.
- At most one outstanding transfer. No pipelining, no bursts, no `err`/`rty` termination.
- Outside BUS, every `wb_o` field is 0.
- **Error flag**
  - `err_clr_i` clears `err_o` on the next edge.
  - If a timeout occurs in the same cycle as `err_clr_i`, the set wins.
  - `err_addr_o` is never cleared except by reset.
- **Reset**
  - Async assertion forces IDLE immediately, even mid-transfer. The Wishbone request drops without waiting for `ack`.
  - Reset values: `mem_ready_o` = 0, `mem_rdata_o` = 0, `wb_o` = all zeros, `err_o` = 0, `err_addr_o` = 0, counter = 0.
  - A late `ack` arriving after reset, in IDLE, is ignored.

## Timing
- Edge numbering:
  - `mem_valid_i` is sampled at edge E0.
  - `cyc`/`stb` are high from E0 until the terminating edge.
  - A slave with combinational `ack` is sampled at E1.
  - `mem_ready_o` is high E1–E2.
- Minimum latency: 2 cycles from request sample to ready.
- A slave with N wait states adds N cycles.
- Timeout: `stb` is high for exactly `TIMEOUT_CYCLES` cycles, and `mem_ready_o` is asserted on the following cycle.
- `mem_valid_i` is not sampled in RESP. The CPU drops valid after ready, so the earliest back-to-back request is sampled in IDLE one cycle after the ready pulse.
- Request outputs are registered. There is no combinational path from `mem_*` inputs or `wb_i` to `wb_o`.

## Test plan
- **Read, zero-wait slave:** read 0x1000_0004. Slave acks in the first `stb` cycle with 0x1234_5678. Required: `mem_ready_o` pulse 2 cycles after the request, `mem_rdata_o` = 0x1234_5678, `sel` = 4'hF, `we` = 0.
- **Byte write, 3 wait states:** write 0xA5 with `wstrb` = 4'b0010. Required: `we` = 1, `sel` = 4'b0010, address/data stable for 4 `stb` cycles, one ready pulse, `mem_rdata_o` = 0.
- **Unmapped read, `TIMEOUT_CYCLES` = 16:** read 0xF000_0000 and never ack. Required: `stb` high exactly 16 cycles, `mem_rdata_o` = 0xDEAD_BEEF, `err_o` = 1, `err_addr_o` = 0xF000_0000.
- **Ack in the timeout cycle, `TIMEOUT_CYCLES` = 16:** ack on the 16th `stb` cycle. Required: normal data returned, `err_o` stays 0.
- **Timeout coincident with `err_clr_i`:** assert `err_clr_i` in the timeout cycle. Required: `err_o` = 1. A later `err_clr_i` alone yields `err_o` = 0.
- **Reset mid-transfer:** assert `rst_i` during a wait state, then ack after release. Required: `wb_o` zero immediately, no `mem_ready_o` pulse, all outputs at reset values.
